// File: rtl/ctrl_seq.sv
// Accumulator-CPU sequencer: FETCH/DECODE/EXEC, 3 cycles per instruction with zero-wait memory.
// Memory backpressure via mem_ready stretches FETCH/EXEC; WAIT_MAX stalled cycles land in sticky ERR.
module ctrl_seq #(
    parameter int WAIT_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    input  logic       acc_zero,
    input  logic       acc_neg,
    input  logic       mem_ready,
    output logic [1:0] pcc,
    output logic       ir_ld,
    output logic       acc_ld,
    output logic [2:0] alu_op,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halt,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_HALT   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [1:0] PC_HOLD = 2'd0;
    localparam logic [1:0] PC_LOAD = 2'd1;
    localparam logic [1:0] PC_INC  = 2'd2;
    localparam logic [1:0] PC_SKIP = 2'd3;

    // Last wait count that is still tolerated; one more stalled cycle times out.
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          mem_op, sta_op;

    logic [1:0] pcc_c;
    logic       ir_ld_c, acc_ld_c, addr_sel_c, mem_rd_c, mem_wr_c, halt_c, err_c;
    logic [2:0] alu_op_c;

    always_comb begin
        mem_op = opcode inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6};
        sta_op = (opcode == 4'h2);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)               state_d = S_DECODE;
                else if (wait_q == WAIT_LAST) state_d = S_ERR;
                else                         wait_d  = wait_q + 1'b1;
            end
            S_DECODE: state_d = (opcode == 4'hF) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (mem_op || sta_op) begin
                    if (mem_ready)               state_d = S_FETCH;
                    else if (wait_q == WAIT_LAST) state_d = S_ERR;
                    else                         wait_d  = wait_q + 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcc_c      = PC_HOLD;
        ir_ld_c    = 1'b0;
        acc_ld_c   = 1'b0;
        alu_op_c   = 3'd0;
        addr_sel_c = 1'b0;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        halt_c     = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd_c = 1'b1;
                ir_ld_c  = mem_ready;
            end
            S_EXEC: begin
                case (opcode)
                    4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
                        mem_rd_c   = 1'b1;
                        addr_sel_c = 1'b1;
                        if (mem_ready) begin
                            acc_ld_c = 1'b1;
                            pcc_c    = PC_INC;
                            case (opcode)
                                4'h3:    alu_op_c = 3'd1;
                                4'h4:    alu_op_c = 3'd2;
                                4'h5:    alu_op_c = 3'd3;
                                4'h6:    alu_op_c = 3'd4;
                                default: alu_op_c = 3'd0;
                            endcase
                        end
                    end
                    4'h2: begin
                        mem_wr_c   = 1'b1;
                        addr_sel_c = 1'b1;
                        if (mem_ready) pcc_c = PC_INC;
                    end
                    4'h7: begin
                        acc_ld_c = 1'b1;
                        alu_op_c = 3'd5;
                        pcc_c    = PC_INC;
                    end
                    4'h8:    pcc_c = PC_LOAD;
                    4'h9:    pcc_c = acc_zero ? PC_LOAD : PC_INC;
                    4'hA:    pcc_c = acc_neg  ? PC_LOAD : PC_INC;
                    4'hB:    pcc_c = acc_zero ? PC_SKIP : PC_INC;
                    default: pcc_c = PC_INC;
                endcase
            end
            S_HALT:  halt_c = 1'b1;
            S_ERR:   err_c  = 1'b1;
            default: ;
        endcase
    end

    // Outputs are held low for the whole time reset is asserted, not just until the next edge.
    always_comb begin
        pcc      = clr ? pcc_c      : PC_HOLD;
        ir_ld    = clr & ir_ld_c;
        acc_ld   = clr & acc_ld_c;
        alu_op   = clr ? alu_op_c   : 3'd0;
        addr_sel = clr & addr_sel_c;
        mem_rd   = clr & mem_rd_c;
        mem_wr   = clr & mem_wr_c;
        halt     = clr & halt_c;
        err      = clr & err_c;
        state    = clr ? state_q    : S_FETCH;
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized bench for ctrl_seq against an instruction-level model of the expected cycle trace.
module tb_ctrl_seq;

    localparam int WMAX = 15;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       acc_zero = 1'b0;
    logic       acc_neg = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] pcc;
    logic       ir_ld, acc_ld, addr_sel, mem_rd, mem_wr, halt, err;
    logic [2:0] alu_op, state;

    int n_chk  = 0;
    int n_fail = 0;

    ctrl_seq #(.WAIT_MAX(WMAX), .CW(4)) dut (
        .clk(clk), .clr(clr), .opcode(opcode), .acc_zero(acc_zero), .acc_neg(acc_neg),
        .mem_ready(mem_ready), .pcc(pcc), .ir_ld(ir_ld), .acc_ld(acc_ld), .alu_op(alu_op),
        .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .halt(halt), .err(err),
        .state(state)
    );

    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {pcc, ir_ld, acc_ld, alu_op, addr_sel, mem_rd, mem_wr, halt, err, state};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [14:0] pk(input logic [1:0] p, input logic ir, input logic al,
                                       input logic [2:0] op, input logic as, input logic rd,
                                       input logic wr, input logic h, input logic e,
                                       input logic [2:0] st);
        return {p, ir, al, op, as, rd, wr, h, e, st};
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            4'h3: return 3'd1;
            4'h4: return 3'd2;
            4'h5: return 3'd3;
            4'h6: return 3'd4;
            4'h7: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] pc_of(input logic [3:0] op, input logic z, input logic n);
        case (op)
            4'h8: return 2'd1;
            4'h9: return z ? 2'd1 : 2'd2;
            4'hA: return n ? 2'd1 : 2'd2;
            4'hB: return z ? 2'd3 : 2'd2;
            default: return 2'd2;
        endcase
    endfunction

    // Called at posedge+1; drives one cycle, compares at negedge, returns at next posedge+1.
    task automatic cyc(input string tag, input logic rdy, input logic [14:0] want);
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, 32'(obs), 32'(want));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        mem_ready = 1'b0;
        #1 chk("rst_outs_zero", 32'(obs), 32'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        #1 chk("rst_release", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
    endtask

    // stuck=1 leaves the exec memory access unanswered until the timeout.
    task automatic do_instr(input logic [3:0] op, input int df, input int de,
                            input logic z, input logic n, input bit stuck);
        int  last_i;
        logic last;
        acc_zero = z;
        acc_neg  = n;
        opcode   = 4'($urandom);
        for (int i = 0; i <= df; i++)
            cyc("fetch", 1'(i == df), pk(0, 1'(i == df), 0, 0, 0, 1, 0, 0, 0, 0));
        opcode = op;
        cyc("decode", 1'($urandom), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        if (op == 4'hF) return;
        last_i = stuck ? WMAX - 1 : de;
        if (op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6}) begin
            for (int i = 0; i <= last_i; i++) begin
                last = !stuck && (i == last_i);
                cyc("exec_rd", last, pk(last ? 2'd2 : 2'd0, 0, last, last ? alu_of(op) : 3'd0,
                                        1, 1, 0, 0, 0, 2));
            end
        end else if (op == 4'h2) begin
            for (int i = 0; i <= last_i; i++) begin
                last = !stuck && (i == last_i);
                cyc("exec_wr", last, pk(last ? 2'd2 : 2'd0, 0, 0, 0, 1, 0, 1, 0, 0, 2));
            end
        end else begin
            cyc("exec_1cyc", 1'($urandom), pk(pc_of(op, z, n), 0, 1'(op == 4'h7), alu_of(op),
                                              0, 0, 0, 0, 0, 2));
        end
    endtask

    initial begin
        #1 chk("reset_state", 32'(obs), 32'd0);
        do_reset();

        // ADD interrupted by reset in its completing EXEC cycle
        cyc("fetch_add", 1'b1, pk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        opcode = 4'h3;
        cyc("decode_add", 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        mem_ready = 1'b1;
        #1 chk("exec_add_live", 32'(obs), 32'(pk(2, 0, 1, 3'd1, 1, 1, 0, 0, 0, 2)));
        do_reset();

        do_instr(4'h1, 2, 2, 0, 0, 0);
        do_instr(4'h3, 2, 2, 0, 0, 0);
        do_instr(4'h2, 2, 2, 0, 0, 0);
        do_instr(4'h9, 0, 0, 1, 0, 0);
        do_instr(4'h9, 0, 0, 0, 1, 0);
        do_instr(4'hB, 0, 0, 1, 0, 0);
        do_instr(4'hA, 0, 0, 0, 1, 0);
        do_instr(4'h7, 1, 0, 0, 0, 0);
        do_instr(4'h8, 0, 0, 1, 1, 0);
        do_instr(4'h1, WMAX - 1, WMAX - 1, 0, 0, 0);
        do_instr(4'h2, 0, WMAX - 1, 0, 0, 0);

        repeat (200) begin
            do_instr(4'($urandom_range(0, 14)), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), 0);
        end

        do_instr(4'hF, 1, 0, 0, 0, 0);
        repeat (20) cyc("halt_hold", 1'($urandom), pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3));
        do_reset();
        do_instr(4'h0, 0, 0, 0, 0, 0);

        for (int i = 0; i < WMAX; i++)
            cyc("fetch_stall", 1'b0, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        repeat (5) cyc("fetch_timeout", 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4));
        do_reset();

        do_instr(4'h2, 0, 0, 0, 0, 1);
        repeat (5) cyc("exec_timeout", 1'($urandom), pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4));
        do_reset();
        do_instr(4'h4, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
